neuron_mac: RTL
===============

Name: neuron_mac

Overview:
- Per-neuron multiply-accumulate stage that sits directly upstream of the ReLU activation stage.
- Consumes a stream of signed fixed-point (feature, weight) pairs for one neuron and accumulates `numInputs` products at full precision.
- Adds the neuron bias, then rescales and saturates the sum to `featureWidth`.
- Emits the pre-activation value with a one-cycle valid strobe; the ReLU takes `y_out` as its `x` and `out_valid` as its `enable`.

Parameters:
- weightWidth, 16, signed weight width (two's complement, Q with `fracBits` fractional bits)
- featureWidth, 16, signed feature/bias/output width (same Q format)
- fracBits, 8, fractional bits shared by features, weights and bias
- numInputs, 4, pairs accumulated per neuron (>=1)
- accWidth, 40, accumulator width; must be >= weightWidth+featureWidth+clog2(numInputs)+1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a new neuron; sampled only in IDLE
- bias  in  featureWidth  signed bias; captured on accepted start
- in_valid  in  1  x_in/w_in pair valid
- x_in  in  featureWidth  signed feature
- w_in  in  weightWidth  signed weight
- in_ready  out  1  pair accepted when in_valid & in_ready
- busy  out  1  high in any state other than IDLE
- out_valid  out  1  one-cycle strobe; y_out new this cycle
- y_out  out  featureWidth  signed saturated pre-activation result
- overflow  out  1  saturation occurred on this result; valid with out_valid, held with y_out

Behaviour:
- Reset (`rst_n`=0 at a clk edge), regardless of state:
  - state=IDLE; acc, count, bias register = 0.
  - in_ready=0, busy=0, out_valid=0, y_out=0, overflow=0.
  - Reset mid-operation aborts the neuron; no out_valid follows.
- FSM states IDLE, ACCUM, SCALE:
  - IDLE: in_ready=0. On start=1: capture bias, acc<=0, count<=0, go to ACCUM. start is ignored in any other state.
  - ACCUM: in_ready=1.
    - Each accept: acc <= acc + sign-extended (x_in*w_in), count<=count+1.
    - in_valid=0 stalls; acc and count hold.
    - When the accept brings count to numInputs, go to SCALE. in_ready is 0 from the next cycle.
  - SCALE: one cycle, combinational only.
    - s = acc + (sign-extended bias << fracBits)
    - r = s >>> fracBits (arithmetic shift, i.e. floor)
    - If r > 2^(featureWidth-1)-1: y_out = max positive, overflow=1.
    - If r < -2^(featureWidth-1): y_out = most negative, overflow=1.
    - Otherwise y_out = r[featureWidth-1:0], overflow=0.
    - y_out, overflow and out_valid<=1 are registered at the end of SCALE; go to IDLE.
- Latency:
  - Last pair accepted at edge k → out_valid=1 during the cycle after edge k+1, for exactly one cycle.
  - A start may be presented in that same out_valid cycle (state is IDLE).
- y_out and overflow hold until the next result or reset. out_valid is 0 in all other cycles.
- Product width weightWidth+featureWidth, signed multiply. Accumulator does not wrap for legal accWidth.

Optional Feature:
- Macro: NEURON_MAC_ROUND_EN
- Defined: SCALE computes r = (s + 2^(fracBits-1)) >>> fracBits, i.e. round half toward +inf, before saturation.
- Undefined: truncation (floor) exactly as above. No port or latency change.

Test Plan:
- Basic result: start, bias=0x0040; 4 pairs x=0x0100, w=0x0080, back-to-back → out_valid 2 cycles after last accept, y_out=0x0240, overflow=0, busy low the cycle out_valid rises.
- Negative result: bias=0; 4× (x=0x0100, w=0xFF00) → y_out=0xFC00, overflow=0. With the downstream ReLU attached, its output is 0.
- Saturation and stall: 4× (0x7FFF, 0x7FFF) with in_valid gaps of 3 cycles → y_out=0x7FFF, overflow=1, count unaffected by gaps. 4× (0x8000, 0x7FFF) → y_out=0x8000, overflow=1.
- Rounding: bias=0; pairs (0x0001, 0x0080), then 3× (0, 0) → y_out=0x0000 without the macro, 0x0001 with it. Repeat with w=0xFF80 → 0xFFFF without, 0x0000 with.
- Reset and start filtering:
  - Assert rst_n=0 after 2 accepts → next cycle all outputs 0, state IDLE.
  - A fresh 4-pair neuron then gives the correct result with no stale accumulation.
  - start pulsed during ACCUM is ignored.

Source files
------------

// File: rtl/neuron_mac_if.sv
// Handshake and data bundle between a neuron_mac and its feature/weight source and result sink.
// master = upstream driver/downstream consumer side, slave = the MAC itself.
interface neuron_mac_if #(
   parameter int featureWidth = 16,
   parameter int weightWidth  = 16
);
   logic                           start;
   logic signed [featureWidth-1:0] bias;
   logic                           in_valid;
   logic signed [featureWidth-1:0] x_in;
   logic signed [weightWidth-1:0]  w_in;
   logic                           in_ready;
   logic                           busy;
   logic                           out_valid;
   logic signed [featureWidth-1:0] y_out;
   logic                           overflow;

   modport master (
      output start, bias, in_valid, x_in, w_in,
      input  in_ready, busy, out_valid, y_out, overflow
   );

   modport slave (
      input  start, bias, in_valid, x_in, w_in,
      output in_ready, busy, out_valid, y_out, overflow
   );
endinterface

// File: rtl/neuron_mac.sv
// Per-neuron signed MAC: accumulates numInputs products, adds bias, rescales and saturates.
// Result strobes out_valid 2 cycles after the last accepted pair; in_valid low stalls accumulation.
// NEURON_MAC_ROUND_EN selects round-half-up instead of floor when rescaling.
module neuron_mac #(
   parameter int weightWidth  = 16,
   parameter int featureWidth = 16,
   parameter int fracBits     = 8,
   parameter int numInputs    = 4,
   parameter int accWidth     = 40
) (
   input logic         clk,
   input logic         rst_n,
   neuron_mac_if.slave bus
);
   localparam int PW = featureWidth + weightWidth;
   localparam int CW = $clog2(numInputs + 1);
   localparam logic [CW-1:0] LAST = CW'(numInputs - 1);
   localparam logic signed [accWidth-1:0] MAXV =
      {{(accWidth-featureWidth+1){1'b0}}, {(featureWidth-1){1'b1}}};
   localparam logic signed [accWidth-1:0] MINV =
      {{(accWidth-featureWidth+1){1'b1}}, {(featureWidth-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

   state_t                         state;
   logic signed [accWidth-1:0]     acc;
   logic [CW-1:0]                  count;
   logic signed [featureWidth-1:0] bias_q;
   logic                           in_ready_q;
   logic                           busy_q;
   logic                           out_valid_q;
   logic                           overflow_q;
   logic signed [featureWidth-1:0] y_q;

   logic signed [PW-1:0]           prod;
   logic signed [accWidth-1:0]     prod_ext;
   logic signed [accWidth-1:0]     bias_sh;
   logic signed [accWidth-1:0]     sum;
   logic signed [accWidth-1:0]     sum_adj;
   logic signed [accWidth-1:0]     r;
   logic signed [featureWidth-1:0] y_sat;
   logic                           ovf_sat;

   assign prod     = bus.x_in * bus.w_in;
   assign prod_ext = {{(accWidth-PW){prod[PW-1]}}, prod};
   assign bias_sh  = {{(accWidth-featureWidth){bias_q[featureWidth-1]}}, bias_q} <<< fracBits;
   assign sum      = acc + bias_sh;

`ifdef NEURON_MAC_ROUND_EN
   localparam logic signed [accWidth-1:0] HALF = accWidth'(1) <<< (fracBits - 1);
   assign sum_adj = sum + HALF;
`else
   assign sum_adj = sum;
`endif

   // Arithmetic shift on a signed operand: floor toward -inf.
   assign r = sum_adj >>> fracBits;

   always_comb begin
      y_sat   = r[featureWidth-1:0];
      ovf_sat = 1'b0;
      if (r > MAXV) begin
         y_sat   = {1'b0, {(featureWidth-1){1'b1}}};
         ovf_sat = 1'b1;
      end else if (r < MINV) begin
         y_sat   = {1'b1, {(featureWidth-1){1'b0}}};
         ovf_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         count       <= '0;
         bias_q      <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         y_q         <= '0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bias_q     <= bus.bias;
                  acc        <= '0;
                  count      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= ACCUM;
               end
            end
            ACCUM: begin
               if (bus.in_valid && in_ready_q) begin
                  acc   <= acc + prod_ext;
                  count <= count + CW'(1);
                  if (count == LAST) begin
                     in_ready_q <= 1'b0;
                     state      <= SCALE;
                  end
               end
            end
            SCALE: begin
               y_q         <= y_sat;
               overflow_q  <= ovf_sat;
               out_valid_q <= 1'b1;
               busy_q      <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.y_out     = y_q;
   assign bus.overflow  = overflow_q;
endmodule
